// File: rtl/multiplication_pipe.sv
// Three-stage multi-lane multiplier: BF16 x BF16 -> BF16 (round to nearest even)
// or 8x8 -> 16-bit integer, selected per transaction. The whole pipe advances
// together whenever the output register is empty or being consumed.
module multiplication_pipe #(
  parameter int LANES       = 1,
  parameter bit SIGNED_INT8 = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic                  i_int8,
  input  logic [16*LANES-1:0]   i_a,
  input  logic [16*LANES-1:0]   i_b,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [16*LANES-1:0]   o_res,
  output logic [3*LANES-1:0]    o_flags
);

  logic advance;
  logic s1_valid_reg, s2_valid_reg, s3_valid_reg;
  logic s1_int8_reg, s2_int8_reg;

  // Pipe moves as a unit; bubbles are kept in place during a stall.
  assign advance = !s3_valid_reg || i_ready;
  assign o_ready = advance;
  assign o_valid = s3_valid_reg;

  // Stage valid bits and the mode bit that travels with each transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
      s3_valid_reg <= 1'b0;
      s1_int8_reg  <= 1'b0;
      s2_int8_reg  <= 1'b0;
    end else if (advance) begin
      s1_valid_reg <= i_valid;
      s2_valid_reg <= s1_valid_reg;
      s3_valid_reg <= s2_valid_reg;
      s1_int8_reg  <= i_int8;
      s2_int8_reg  <= s1_int8_reg;
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [15:0] a_lane, b_lane;
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

    logic              sign1_reg, nan1_reg, inf1_reg, zero1_reg, inv1_reg;
    logic signed [9:0] exp1_reg;
    logic [7:0]        ma1_reg, mb1_reg;

    logic [15:0]        prod_u;
    logic signed [15:0] prod_s;
    logic               sign2_reg, nan2_reg, inf2_reg, zero2_reg, inv2_reg;
    logic signed [9:0]  exp2_reg;
    logic [15:0]        prod2_reg;

    logic [7:0]         mant;
    logic               guard, sticky, rnd;
    logic [8:0]         mant_r;
    logic signed [9:0]  exp_n, exp_r;
    logic [6:0]         frac;
    logic [15:0]        res_next;
    logic [2:0]         flags_next;
    logic [15:0]        res_reg;
    logic [2:0]         flags_reg;

    assign a_lane = i_a[16*gi +: 16];
    assign b_lane = i_b[16*gi +: 16];

    // Subnormals (exponent 0) are treated as zero.
    assign a_zero = (a_lane[14:7] == 8'h00);
    assign b_zero = (b_lane[14:7] == 8'h00);
    assign a_inf  = (a_lane[14:7] == 8'hFF) && (a_lane[6:0] == 7'd0);
    assign b_inf  = (b_lane[14:7] == 8'hFF) && (b_lane[6:0] == 7'd0);
    assign a_nan  = (a_lane[14:7] == 8'hFF) && (a_lane[6:0] != 7'd0);
    assign b_nan  = (b_lane[14:7] == 8'hFF) && (b_lane[6:0] != 7'd0);

    // S1: unpack operands and classify special cases.
    always_ff @(posedge clk) begin
      if (advance) begin
        sign1_reg <= a_lane[15] ^ b_lane[15];
        exp1_reg  <= $signed({2'b00, a_lane[14:7]}) + $signed({2'b00, b_lane[14:7]}) - 10'sd127;
        ma1_reg   <= i_int8 ? a_lane[7:0] : {1'b1, a_lane[6:0]};
        mb1_reg   <= i_int8 ? b_lane[7:0] : {1'b1, b_lane[6:0]};
        inv1_reg  <= (a_inf && b_zero) || (a_zero && b_inf);
        nan1_reg  <= a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf);
        inf1_reg  <= a_inf || b_inf;
        zero1_reg <= a_zero || b_zero;
      end
    end

    assign prod_u = ma1_reg * mb1_reg;
    assign prod_s = $signed(ma1_reg) * $signed(mb1_reg);

    // S2: significand or integer multiply.
    always_ff @(posedge clk) begin
      if (advance) begin
        prod2_reg <= (SIGNED_INT8 && s1_int8_reg) ? 16'(prod_s) : prod_u;
        sign2_reg <= sign1_reg;
        exp2_reg  <= exp1_reg;
        nan2_reg  <= nan1_reg;
        inf2_reg  <= inf1_reg;
        zero2_reg <= zero1_reg;
        inv2_reg  <= inv1_reg;
      end
    end

    // S3 datapath: normalise, round to nearest even, then apply special cases.
    always_comb begin
      mant       = prod2_reg[14:7];
      guard      = prod2_reg[6];
      sticky     = |prod2_reg[5:0];
      exp_n      = exp2_reg;
      if (prod2_reg[15]) begin
        mant   = prod2_reg[15:8];
        guard  = prod2_reg[7];
        sticky = |prod2_reg[6:0];
        exp_n  = exp2_reg + 10'sd1;
      end
      rnd        = guard && (sticky || mant[0]);
      mant_r     = {1'b0, mant} + {8'd0, rnd};
      exp_r      = mant_r[8] ? exp_n + 10'sd1 : exp_n;
      frac       = mant_r[8] ? mant_r[7:1] : mant_r[6:0];
      res_next   = {sign2_reg, exp_r[7:0], frac};
      flags_next = 3'b000;
      if (s2_int8_reg) begin
        res_next = prod2_reg;
      end else if (nan2_reg) begin
        res_next   = 16'h7FC0;
        flags_next = {inv2_reg, 2'b00};
      end else if (inf2_reg) begin
        res_next = {sign2_reg, 8'hFF, 7'd0};
      end else if (zero2_reg) begin
        res_next = {sign2_reg, 15'd0};
      end else if (exp_r >= 10'sd255) begin
        res_next   = {sign2_reg, 8'hFF, 7'd0};
        flags_next = 3'b010;
      end else if (exp_r <= 10'sd0) begin
        res_next   = {sign2_reg, 15'd0};
        flags_next = 3'b001;
      end
    end

    // S3 register: output only changes when a real transaction moves in.
    always_ff @(posedge clk) begin
      if (rst) begin
        res_reg   <= 16'd0;
        flags_reg <= 3'd0;
      end else if (advance && s2_valid_reg) begin
        res_reg   <= res_next;
        flags_reg <= flags_next;
      end
    end

    assign o_res[16*gi +: 16]  = res_reg;
    assign o_flags[3*gi +: 3]  = flags_reg;
  end

endmodule
